// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - CPU-side push bus and transmitter-side strobe bundle for uart_tx_fifo
//
// Purpose: groups the push port, status flags and the write-strobe link to the
//          downstream UART transmitter.
// Ports (signals):
//   wr_en, wr_data, ovf_clr        push request, byte, overflow clear
//   full, empty, level, overflow   registered FIFO status
//   tx_busy                        drain engine not idle
//   uart_we, uart_di, uart_wait    transmitter write strobe, data, busy reply
// Modports: slave = the FIFO, master = CPU bus plus transmitter.
interface uart_tx_fifo_if #(
    parameter int DEPTH = 16
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic          wr_en;
    logic [7:0]    wr_data;
    logic          ovf_clr;
    logic          full;
    logic          empty;
    logic [LW-1:0] level;
    logic          overflow;
    logic          tx_busy;
    logic          uart_we;
    logic [31:0]   uart_di;
    logic          uart_wait;

    modport slave (
        input  wr_en, wr_data, ovf_clr, uart_wait,
        output full, empty, level, overflow, tx_busy, uart_we, uart_di
    );

    modport master (
        output wr_en, wr_data, ovf_clr, uart_wait,
        input  full, empty, level, overflow, tx_busy, uart_we, uart_di
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO that paces bytes into a UART transmitter
//
// Purpose: buffers CPU bytes and hands them one at a time to a UART transmitter,
//          holding each byte on uart_di for a fixed gap after acceptance.
// Ports:
//   clk     sole clock, rising edge
//   resetn  asynchronous active-low reset
//   bus     uart_tx_fifo_if.slave (push bus, status, transmitter strobe)
// Parameters: DEPTH (power of two, 2..256), DELAY_FRAMES (clocks per bit),
//             GAP_CYCLES (hold time after downstream acceptance).
module uart_tx_fifo #(
    parameter int DEPTH        = 16,
    parameter int DELAY_FRAMES = 10,
    parameter int GAP_CYCLES   = 12 * DELAY_FRAMES
) (
    input  logic            clk,
    input  logic            resetn,
    uart_tx_fifo_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ISSUE, S_HOLD} state_t;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic          r_full;
    logic          r_empty;
    logic          r_ovf;
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [7:0]    r_hold;
    logic          r_we;

    logic          w_push;
    logic          w_pop;
    logic [LW-1:0] w_level_nxt;

    // A push against a full FIFO is dropped even if a pop frees a slot on the
    // same edge, so acceptance looks only at the registered full flag.
    assign w_push = bus.wr_en && !r_full;
    // LOAD is only entered with a non-empty FIFO, so it always pops.
    assign w_pop  = (r_state == S_LOAD);

    always_comb begin
        w_level_nxt = r_level;
        case ({w_push, w_pop})
            2'b10:   w_level_nxt = r_level + LW'(1);
            2'b01:   w_level_nxt = r_level - LW'(1);
            default: w_level_nxt = r_level;
        endcase
    end

    // Storage array needs no reset: contents are only visible through the pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_ovf    <= 1'b0;
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_hold   <= 8'h00;
            r_we     <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_level <= w_level_nxt;
            r_full  <= (w_level_nxt == LW'(DEPTH));
            r_empty <= (w_level_nxt == '0);

            // A dropped push on the same edge as a clear keeps the flag set.
            if (bus.wr_en && r_full) begin
                r_ovf <= 1'b1;
            end else if (bus.ovf_clr) begin
                r_ovf <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    r_we <= 1'b0;
                    if (!r_empty) begin
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_hold  <= r_mem[r_rd_ptr];
                    r_we    <= 1'b1;
                    r_state <= S_ISSUE;
                end
                S_ISSUE: begin
                    // Transmitter takes the byte on this edge when not busy;
                    // otherwise keep strobing with the same data.
                    if (!bus.uart_wait) begin
                        r_we    <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    // r_hold stays put here so uart_di is stable across the
                    // transmitter's latch point at the end of its start bit.
                    r_we <= 1'b0;
                    if (r_cnt == CW'(GAP_CYCLES - 1)) begin
                        r_state <= r_empty ? S_IDLE : S_LOAD;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_we    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.full     = r_full;
    assign bus.empty    = r_empty;
    assign bus.level    = r_level;
    assign bus.overflow = r_ovf;
    assign bus.tx_busy  = (r_state != S_IDLE);
    assign bus.uart_we  = r_we;
    assign bus.uart_di  = {24'h0, r_hold};
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed self-checking bench for uart_tx_fifo with a serial transmitter model
module tb_uart_tx_fifo;
    localparam int DEPTH = 16;
    localparam int DF    = 10;
    localparam int GAP   = 120;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    logic force_wait = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    uart_tx_fifo_if #(.DEPTH(DEPTH)) bus ();

    uart_tx_fifo #(
        .DEPTH(DEPTH),
        .DELAY_FRAMES(DF),
        .GAP_CYCLES(GAP)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Downstream transmitter model: 1 start, 8 data LSB first, 1 stop, DF clocks per bit.
    logic       m_busy = 1'b0;
    logic [9:0] m_sh   = 10'h3FF;
    int         m_bits = 0;
    int         m_clk  = 0;
    logic       ser_tx;

    assign ser_tx        = m_busy ? m_sh[0] : 1'b1;
    assign bus.uart_wait = force_wait | m_busy;

    always @(posedge clk) begin
        if (!m_busy) begin
            if (bus.uart_we && !bus.uart_wait) begin
                m_sh   <= {1'b1, bus.uart_di[7:0], 1'b0};
                m_busy <= 1'b1;
                m_bits <= 0;
                m_clk  <= 0;
            end
        end else if (m_clk == DF - 1) begin
            m_clk <= 0;
            m_sh  <= {1'b1, m_sh[9:1]};
            if (m_bits == 9) m_busy <= 1'b0;
            else             m_bits <= m_bits + 1;
        end else begin
            m_clk <= m_clk + 1;
        end
    end

    // Serial decoder sampling mid-bit on falling clock edges.
    logic [7:0] rx_q[$];
    int         frame_err = 0;
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge ser_tx);
            repeat (15) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                b[i] = ser_tx;
                repeat (DF) @(negedge clk);
            end
            if (ser_tx !== 1'b1) frame_err++;
            rx_q.push_back(b);
        end
    end

    // Strobe monitor: records every accepted byte and its cycle number.
    logic [7:0] acc_q[$];
    int         acc_cyc[$];
    int         we_cycles = 0;
    int         we_viol   = 0;
    initial begin
        logic prev_we;
        logic prev_wait;
        prev_we   = 1'b0;
        prev_wait = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.uart_we) we_cycles++;
            if (bus.uart_we && prev_we && !prev_wait) we_viol++;
            if (bus.uart_we && !bus.uart_wait) begin
                acc_q.push_back(bus.uart_di[7:0]);
                acc_cyc.push_back(cyc);
            end
            prev_we   = bus.uart_we;
            prev_wait = bus.uart_wait;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag, input int max_cyc);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            tick();
            if (!bus.tx_busy && !m_busy && bus.empty) begin
                ok = 1'b1;
                break;
            end
        end
        check(tag, ok, 1'b1);
    endtask

    logic [7:0] exp_q[$];
    int         n_acc;
    int         we0;
    int         k;

    initial begin
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        bus.ovf_clr = 1'b0;

        // Reset state
        repeat (3) tick();
        resetn = 1'b1;
        tick();
        @(negedge clk);
        check("rst_empty", bus.empty, 1'b1);
        check("rst_full", bus.full, 1'b0);
        check("rst_level", bus.level, 0);
        check("rst_ovf", bus.overflow, 1'b0);
        check("rst_busy", bus.tx_busy, 1'b0);
        check("rst_we", bus.uart_we, 1'b0);
        check("rst_di", bus.uart_di, 32'h0);

        // Single byte latency
        tick();
        bus.wr_en = 1'b1; bus.wr_data = 8'h41;
        tick();                                   // edge N
        bus.wr_en = 1'b0;
        @(negedge clk);
        check("lat_n_empty", bus.empty, 1'b0);
        check("lat_n_level", bus.level, 1);
        check("lat_n_we", bus.uart_we, 1'b0);
        tick();                                   // edge N+1
        @(negedge clk);
        check("lat_n1_we", bus.uart_we, 1'b0);
        check("lat_n1_busy", bus.tx_busy, 1'b1);
        tick();                                   // edge N+2
        @(negedge clk);
        check("lat_n2_we", bus.uart_we, 1'b1);
        check("lat_n2_di", bus.uart_di, 32'h00000041);
        check("lat_n2_empty", bus.empty, 1'b1);
        tick();                                   // edge N+3, accepted
        @(negedge clk);
        check("lat_n3_we", bus.uart_we, 1'b0);
        check("lat_n3_di", bus.uart_di, 32'h00000041);
        exp_q.push_back(8'h41);
        wait_idle("idle_single", 400);

        // uart_wait stall for 5 cycles
        force_wait = 1'b1;
        bus.wr_en = 1'b1; bus.wr_data = 8'h33;
        tick();
        bus.wr_en = 1'b0;
        we0 = we_cycles;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.uart_we && k < 10);
        check("stall_we1", bus.uart_we, 1'b1);
        check("stall_di1", bus.uart_di, 32'h33);
        for (int i = 2; i <= 5; i++) begin
            tick();
            @(negedge clk);
            check($sformatf("stall_we%0d", i), bus.uart_we, 1'b1);
            check($sformatf("stall_di%0d", i), bus.uart_di, 32'h33);
        end
        tick();
        force_wait = 1'b0;
        @(negedge clk);
        check("stall_we6", bus.uart_we, 1'b1);
        tick();
        @(negedge clk);
        check("stall_we7", bus.uart_we, 1'b0);
        check("stall_di7", bus.uart_di, 32'h33);
        check("stall_cnt", we_cycles - we0, 6);
        exp_q.push_back(8'h33);
        wait_idle("idle_stall", 400);

        // Fill to full behind a stalled byte, overflow, then push+pop at full
        force_wait = 1'b1;
        bus.wr_en = 1'b1; bus.wr_data = 8'h55;
        tick();
        exp_q.push_back(8'h55);
        for (int i = 0; i < 16; i++) begin
            bus.wr_data = 8'h10 + 8'(i);
            exp_q.push_back(8'h10 + 8'(i));
            tick();
        end
        bus.wr_data = 8'hEE;
        @(negedge clk);
        check("fill_full", bus.full, 1'b1);
        check("fill_level", bus.level, 16);
        check("fill_ovf0", bus.overflow, 1'b0);
        tick();                                   // 17th push dropped
        bus.wr_en = 1'b0;
        @(negedge clk);
        check("fill_ovf1", bus.overflow, 1'b1);
        check("fill_level_drop", bus.level, 16);
        tick();
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        @(negedge clk);
        check("ovf_clr", bus.overflow, 1'b0);
        tick();
        force_wait = 1'b0;
        bus.wr_en = 1'b1; bus.wr_data = 8'hEE;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (bus.level == 16 && k < 400);
        check("pp_level", bus.level, 15);
        check("pp_ovf", bus.overflow, 1'b1);
        check("pp_full", bus.full, 1'b0);
        bus.wr_data = 8'h20;
        exp_q.push_back(8'h20);
        tick();
        bus.wr_data = 8'hEE; bus.ovf_clr = 1'b1;
        tick();
        bus.wr_en = 1'b0; bus.ovf_clr = 1'b0;
        @(negedge clk);
        check("clr_vs_set_ovf", bus.overflow, 1'b1);
        check("clr_vs_set_level", bus.level, 16);
        check("clr_vs_set_full", bus.full, 1'b1);
        tick();
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        @(negedge clk);
        check("ovf_clr2", bus.overflow, 1'b0);
        wait_idle("idle_burst", 5000);

        // Reset during HOLD with level 3
        for (int i = 0; i < 4; i++) begin
            bus.wr_en = 1'b1; bus.wr_data = 8'hA0 + 8'(i);
            tick();
        end
        bus.wr_en = 1'b0;
        exp_q.push_back(8'hA0);
        repeat (5) tick();
        @(negedge clk);
        check("hold_level", bus.level, 3);
        check("hold_busy", bus.tx_busy, 1'b1);
        check("hold_we", bus.uart_we, 1'b0);
        resetn = 1'b0;
        #1;
        check("arst_empty", bus.empty, 1'b1);
        check("arst_full", bus.full, 1'b0);
        check("arst_level", bus.level, 0);
        check("arst_ovf", bus.overflow, 1'b0);
        check("arst_busy", bus.tx_busy, 1'b0);
        check("arst_we", bus.uart_we, 1'b0);
        check("arst_di", bus.uart_di, 32'h0);
        n_acc = acc_q.size();
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (400) tick();
        check("post_rst_strobes", acc_q.size(), n_acc);
        check("post_rst_busy", bus.tx_busy, 1'b0);

        // "HI" through the serial model
        bus.wr_en = 1'b1; bus.wr_data = 8'h48;
        tick();
        bus.wr_data = 8'h49;
        tick();
        bus.wr_en = 1'b0;
        exp_q.push_back(8'h48);
        exp_q.push_back(8'h49);
        wait_idle("idle_hi", 600);
        repeat (20) tick();

        // Ordering, spacing and serial decode
        check("acc_count", acc_q.size(), exp_q.size());
        check("rx_count", rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < acc_q.size()) check($sformatf("acc%0d", i), acc_q[i], exp_q[i]);
            if (i < rx_q.size())  check($sformatf("rx%0d", i), rx_q[i], exp_q[i]);
        end
        if (acc_cyc.size() == 23) begin
            for (int i = 3; i <= 19; i++)
                check($sformatf("gap%0d", i), acc_cyc[i] - acc_cyc[i-1], GAP + 2);
            check("gap_hi", acc_cyc[22] - acc_cyc[21], GAP + 2);
        end
        check("frame_err", frame_err, 0);
        check("we_consec", we_viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
